// File: rtl/polara_loopback_pkt_checker.sv
// Loopback packet checker: parses headers on one selected NoC channel,
// counts payload, flags field/length/timeout errors, drains the rest.
module polara_loopback_pkt_checker #(
    parameter logic [13:0] EXP_CHIPID     = 14'b10000000000000,
    parameter logic [7:0]  EXP_XPOS       = 8'd0,
    parameter logic [7:0]  EXP_YPOS       = 8'd0,
    parameter logic [3:0]  EXP_FBITS      = 4'b0010,
    parameter logic [7:0]  EXP_MSG_TYPE   = 8'd18,
    parameter logic [7:0]  MAX_PAYLOAD    = 8'd8,
    parameter int          TIMEOUT_CYCLES = 1024
) (
    input  logic        chipset_clk,
    input  logic        chipset_rst,
    input  logic [1:0]  sw_debounced,
    input  logic        clear,
    input  logic [63:0] intf_chipset_data_noc1,
    input  logic [63:0] intf_chipset_data_noc2,
    input  logic [63:0] intf_chipset_data_noc3,
    input  logic        intf_chipset_val_noc1,
    input  logic        intf_chipset_val_noc2,
    input  logic        intf_chipset_val_noc3,
    output logic        intf_chipset_rdy_noc1,
    output logic        intf_chipset_rdy_noc2,
    output logic        intf_chipset_rdy_noc3,
    output logic        pkt_ok,
    output logic        pkt_err,
    output logic        err_sticky,
    output logic [31:0] pkt_count,
    output logic [15:0] err_count,
    output logic [63:0] last_err_hdr,
    output logic [2:0]  last_err_code
);

    localparam int IDLE_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic {
        S_HDR,
        S_PAYLOAD
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        ch_sel_q;
    logic              rdy_q;
    logic [63:0]       hdr_q;
    logic              mism_q;
    logic [7:0]        remain_q, remain_d;
    logic [IDLE_W-1:0] idle_q, idle_d;

    logic [63:0] cur_data;
    logic        cur_val;
    logic        xfer;
    logic        hdr_mism;
    logic [7:0]  hdr_len;
    logic        hdr_ovs;
    logic        load_hdr;
    logic        done_ok;
    logic        done_err;
    logic [2:0]  err_code_d;
    logic [63:0] err_hdr_d;

    assign intf_chipset_rdy_noc1 = rdy_q;
    assign intf_chipset_rdy_noc2 = rdy_q;
    assign intf_chipset_rdy_noc3 = rdy_q;

    // Ready is low only in the cycle following reset; all channels always drain.
    always_ff @(posedge chipset_clk) begin
        if (chipset_rst) rdy_q <= 1'b0;
        else             rdy_q <= 1'b1;
    end

    // Route the latched channel into the parser; "none" never transfers.
    always_comb begin
        cur_data = '0;
        cur_val  = 1'b0;
        unique case (1'b1)
            (ch_sel_q == 2'b00): begin
                cur_data = intf_chipset_data_noc1;
                cur_val  = intf_chipset_val_noc1;
            end
            (ch_sel_q == 2'b01): begin
                cur_data = intf_chipset_data_noc2;
                cur_val  = intf_chipset_val_noc2;
            end
            (ch_sel_q == 2'b10): begin
                cur_data = intf_chipset_data_noc3;
                cur_val  = intf_chipset_val_noc3;
            end
            default: ;
        endcase
    end

    assign xfer    = cur_val && rdy_q;
    assign hdr_len = cur_data[29:22];
    assign hdr_ovs = hdr_len > MAX_PAYLOAD;

    // Header field check; MSHR and reserved bits are deliberately ignored.
    always_comb begin
        hdr_mism = (cur_data[63:50] != EXP_CHIPID)
                || (cur_data[49:42] != EXP_XPOS)
                || (cur_data[41:34] != EXP_YPOS)
                || (cur_data[33:30] != EXP_FBITS)
                || (cur_data[21:14] != EXP_MSG_TYPE);
    end

    // Next state, payload/idle tracking and completion decode.
    always_comb begin
        state_d    = state_q;
        remain_d   = remain_q;
        idle_d     = idle_q;
        load_hdr   = 1'b0;
        done_ok    = 1'b0;
        done_err   = 1'b0;
        err_code_d = 3'b000;
        err_hdr_d  = hdr_q;
        unique case (state_q)
            S_HDR: begin
                idle_d = '0;
                if (xfer) begin
                    err_hdr_d = cur_data;
                    if (hdr_ovs) begin
                        done_err   = 1'b1;
                        err_code_d = {1'b0, 1'b1, hdr_mism};
                    end else if (hdr_len == 8'd0) begin
                        done_ok    = !hdr_mism;
                        done_err   = hdr_mism;
                        err_code_d = {2'b00, hdr_mism};
                    end else begin
                        load_hdr = 1'b1;
                        remain_d = hdr_len;
                        state_d  = S_PAYLOAD;
                    end
                end
            end
            S_PAYLOAD: begin
                if (xfer) begin
                    idle_d   = '0;
                    remain_d = remain_q - 8'd1;
                    if (remain_q == 8'd1) begin
                        done_ok    = !mism_q;
                        done_err   = mism_q;
                        err_code_d = {2'b00, mism_q};
                        state_d    = S_HDR;
                    end
                end else if (idle_q == IDLE_LAST) begin
                    idle_d     = '0;
                    done_err   = 1'b1;
                    err_code_d = {1'b1, 1'b0, mism_q};
                    state_d    = S_HDR;
                end else begin
                    idle_d = idle_q + IDLE_W'(1);
                end
            end
            default: state_d = S_HDR;
        endcase
    end

    // FSM state, packet context and channel-select latch.
    always_ff @(posedge chipset_clk) begin
        if (chipset_rst) begin
            state_q  <= S_HDR;
            ch_sel_q <= 2'b11;
            hdr_q    <= '0;
            mism_q   <= 1'b0;
            remain_q <= '0;
            idle_q   <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
            idle_q   <= idle_d;
            if (load_hdr) begin
                hdr_q  <= cur_data;
                mism_q <= hdr_mism;
            end
            if (state_q == S_HDR && !xfer) ch_sel_q <= sw_debounced;
        end
    end

    // Result pulses, saturating counters and error capture; clear wins.
    always_ff @(posedge chipset_clk) begin
        if (chipset_rst || clear) begin
            pkt_ok        <= 1'b0;
            pkt_err       <= 1'b0;
            err_sticky    <= 1'b0;
            pkt_count     <= '0;
            err_count     <= '0;
            last_err_hdr  <= '0;
            last_err_code <= '0;
        end else begin
            pkt_ok  <= done_ok;
            pkt_err <= done_err;
            if (done_ok && pkt_count != 32'hFFFF_FFFF)
                pkt_count <= pkt_count + 32'd1;
            if (done_err) begin
                if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
                err_sticky    <= 1'b1;
                last_err_hdr  <= err_hdr_d;
                last_err_code <= err_code_d;
            end
        end
    end

endmodule

// File: doc/polara_loopback_pkt_checker.md
Name: polara_loopback_pkt_checker

Overview:
- Consumes flits the chip returns on its three outbound NoC channels in the Polara FPGA loopback chipset. Sits directly downstream of the chip-to-chipset interface and is the companion of the dummy-packet generator.
- Parses headers on one switch-selected channel, counts payload flits, and checks each field against expected values.
- Keeps packet/error counters and captures the most recent failing header for the block design or ILA.
- Drains the unselected channels so the chip never stalls.

Parameters:
- EXP_CHIPID, 14'b10000000000000, expected header CHIPID [63:50]
- EXP_XPOS, 8'd0, expected XPOS [49:42]
- EXP_YPOS, 8'd0, expected YPOS [41:34]
- EXP_FBITS, 4'b0010, expected FBITS [33:30]
- EXP_MSG_TYPE, 8'd18, expected MESSAGE TYPE [21:14] (MSG_TYPE_INV_FWD)
- MAX_PAYLOAD, 8'd8, largest legal PAYLOAD LENGTH [29:22]
- TIMEOUT_CYCLES, 1024, idle cycles allowed mid-packet before abort (≥2)

Ports:
- chipset_clk  in  1  sole clock
- chipset_rst  in  1  synchronous, active-high reset
- sw_debounced  in  2  channel select: 00=noc1, 01=noc2, 10=noc3, 11=none (drain all)
- clear  in  1  sync pulse: zero counters, sticky flag and capture register
- intf_chipset_data_noc1/2/3  in  64 each  flit data from chip
- intf_chipset_val_noc1/2/3  in  1 each  flit valid
- intf_chipset_rdy_noc1/2/3  out  1 each  ready to chip
- pkt_ok  out  1  one-cycle pulse: good packet completed
- pkt_err  out  1  one-cycle pulse: packet failed (field mismatch, oversize or timeout)
- err_sticky  out  1  set on any pkt_err, held until clear/reset
- pkt_count  out  32  good-packet count, saturating at 32'hFFFFFFFF
- err_count  out  16  error count, saturating at 16'hFFFF
- last_err_hdr  out  64  header of most recent failed packet
- last_err_code  out  3  bit0 field mismatch, bit1 oversize, bit2 timeout

Behaviour:
- Reset, synchronous and active-high, sampled on the chipset_clk rising edge:
  - all outputs 0, including all three rdy signals
  - FSM goes to HDR; flit and timeout counters go to 0
  - reset mid-packet discards the packet with no pulse and no count
- rdy: after reset, all three rdy are 1 every cycle. A flit transfers when val&&rdy. Unselected channels are accepted and discarded.
- Channel select is latched into ch_sel only while in HDR with no transfer on the current channel. Changes during PAYLOAD take effect at the next HDR.
- FSM HDR, on selected-channel transfer:
  - compute mismatch = any of CHIPID, XPOS, YPOS, FBITS, MSG_TYPE ≠ expected. MSHR and RESERVED are ignored.
  - oversize = len > MAX_PAYLOAD.
  - if oversize: error immediately, stay in HDR; following flits are parsed as headers.
  - else if len == 0: complete in the same cycle; pkt_ok or pkt_err (mismatch) pulses the next cycle; stay in HDR.
  - else: store header, mismatch flag and remaining = len; go to PAYLOAD.
- FSM PAYLOAD:
  - each transfer decrements remaining and clears the idle counter.
  - on the transfer that makes remaining 0: complete (ok or err per stored mismatch); go to HDR.
  - each cycle with no transfer increments the idle counter. When it reaches TIMEOUT_CYCLES: error with code bit2 and the stored header; go to HDR.
- Completion latency: pkt_ok/pkt_err assert exactly one cycle after the accepting edge of the last flit. pkt_ok and pkt_err are never both high.
- Counter updates:
  - counters, last_err_* and err_sticky update in the same cycle the pulse asserts.
  - last_err_code is the OR of the causes of that packet only.
- Simultaneous clear and completion: clear wins. Counters read 0, then the completion is dropped. The FSM still advances.
- Selection 11: no checking, no counting; FSM stays in HDR.
- Payload flit contents are not checked.

Test Plan:
- Reset, then sel=00; noc1 sends header {14'h2000,8'd0,8'd0,4'b0010,8'd0,8'd18,8'd0,6'd0}. Required: pkt_ok one cycle later, pkt_count=1, err_count=0.
- sel=01; noc2 header with len=3, then 3 payload flits with val gaps of 5 cycles. Required: pkt_ok only after the 3rd flit, pkt_count=1. noc1/noc3 flits sent at the same time are drained (rdy=1) and not counted.
- Header with XPOS=8'd1, len=0. Required: pkt_err, err_count=1, err_sticky=1, last_err_code=3'b001, last_err_hdr equals the sent header.
- Header with len=9 (>8). Required: pkt_err with code 3'b010. The next flit is treated as a header: a valid header then gives pkt_ok.
- Header with len=2, 1 payload flit, then silence for 1024 cycles. Required: pkt_err with code 3'b100 exactly at the timeout, FSM back in HDR; the next good packet gives pkt_ok.
- Assert clear in the same cycle as a completion pulse → counters 0, err_sticky 0. Assert chipset_rst mid-payload → all rdy 0 for that cycle, no pulse, counters 0.
